calc_datapath: RTL and testbench
================================

CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 Parameter SCAN_BITS, default 17, SHALL set the width of the display refresh counter; its top 2 bits select the digit.
REQ-002 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 last_change  input  9  SHALL carry the scan code of the most recent key.
REQ-005 key_down  input  1  SHALL be a one-cycle pulse marking a new press of last_change.
REQ-006 state  input  3  SHALL be the calculator sequencing state: 000 A-tens, 001 A-ones, 010 op, 011 B-tens, 100 B-ones, 101 wait-enter, 110 show-result.
REQ-007 intro  input  2  SHALL be the operator: 00 add, 01 subtract, 10 multiply.
REQ-008 ssd_ctl  output  4  SHALL be the active-low digit enable, with bit 3 as the leftmost digit.
REQ-009 display  output  8  SHALL be the active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 busy  output  1  SHALL be high while a result is being computed.

Function
REQ-011 Digit keys SHALL map 70/69/72/7A/6B/73/74/6C/75/7D to 0-9; every other code SHALL be a non-digit.
REQ-012 On key_down with a digit code, the block SHALL latch A-tens in state 000, A-ones in 001, B-tens in 011 and B-ones in 100; digits in any other state SHALL be ignored.
REQ-013 Operands SHALL be binary, A = 10*tens + ones (0-99); B is formed the same way.
REQ-014 On key_down with code 05A in state 101, the block SHALL snapshot A, B and intro, then raise busy on the next cycle.
REQ-015 busy SHALL stay high for exactly 22 cycles: 1 load cycle, 7 shift-add cycles, and 14 binary-to-BCD cycles; add and subtract SHALL also use the full 22 cycles.
REQ-016 The result SHALL be 14-bit magnitude plus a sign flag: add 0-198; subtract |A-B| with sign = (A<B); multiply 0-9801.
REQ-017 The result BCD SHALL update only when busy falls, so the previous result is held during computation.
REQ-018 A key_down with 05A while busy SHALL be ignored.
REQ-019 When state changes from 110 to 000, all operand digits and the result SHALL clear to 0; an in-flight computation SHALL abort and busy SHALL drop on the next cycle.
REQ-020 Display content by state:
- 000-001: A digits on the right two positions.
- 010: A digits, with the operator glyph (+ = segments b,c,g; - = g; x = b,c,e,f,g) on the leftmost digit.
- 011-101: B digits.
- 110: the result.
REQ-021 A negative result SHALL show only segment g on the leftmost digit, with magnitude on the other three digits (magnitude is at most 99).
REQ-022 The refresh counter SHALL free-run and wrap from all-ones to 0; exactly one ssd_ctl bit SHALL be low at a time, in the order 3,2,1,0.
REQ-023 The decimal point SHALL always be off.

Reset
REQ-024 While reset is low:
- all operand digits, the snapshot, the result, the sign and the refresh counter SHALL be 0;
- busy SHALL be 0;
- ssd_ctl SHALL be 4'b0111 and display SHALL be 8'hFF.
REQ-025 Reset asserted mid-computation SHALL abort it with no partial result retained.

Configuration
REQ-026 With CALC_LEADING_ZERO_BLANK_EN defined, leading zero digits of operands and results SHALL be blanked (display 8'hFF); the rightmost digit SHALL never be blanked.
REQ-027 With CALC_LEADING_ZERO_BLANK_EN undefined, all four digits SHALL show 0-9, the operator glyph, or the minus glyph.

Structure
REQ-028 Package calc_pkg SHALL hold the state codes, operator codes, the digit and enter scan-code constants, and the 7-segment glyph constants.
REQ-029 The sequential double-dabble converter SHALL be a sub-module bin2bcd (14-bit in, 4 BCD digits out, start/done, 14 cycles).

Verification
REQ-030 Scenario: keys 1,2 in states 000/001, op 00, keys 3,4, enter. Required: busy high 22 cycles, then the display reads 0046 (or blank-blank-4-6 with CALC_LEADING_ZERO_BLANK_EN).
REQ-031 Scenario: A=05, B=37, subtract. Required: leftmost digit shows minus, remaining digits 0,3,2.
REQ-032 Scenario: A=99, B=99, multiply. Required: the display reads 9801 after exactly 22 busy cycles.
REQ-033 Scenario: enter pressed again while busy. Required: busy length is unchanged and the result is unchanged.
REQ-034 Scenario: reset pulsed at busy cycle 10. Required: busy goes 0, the result stays 0000, and ssd_ctl is 0111.
REQ-035 Scenario: non-digit code 1C in state 000. Required: no operand change.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// =============================================================================
// Module   : calc_pkg
// Purpose  : State/operator codes, PS/2 key codes and 7-segment glyphs shared
//            by the calculator datapath.
// Revision : 1.0 - initial release
// =============================================================================
package calc_pkg;

  typedef enum logic [2:0] {
    ST_A_TENS     = 3'b000,
    ST_A_ONES     = 3'b001,
    ST_OP         = 3'b010,
    ST_B_TENS     = 3'b011,
    ST_B_ONES     = 3'b100,
    ST_WAIT_ENTER = 3'b101,
    ST_SHOW       = 3'b110
  } calc_state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } calc_op_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_LOAD = 2'd1,
    PH_MUL  = 2'd2,
    PH_BCD  = 2'd3
  } calc_phase_e;

  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_0     = 9'h070;
  localparam logic [8:0] KEY_1     = 9'h069;
  localparam logic [8:0] KEY_2     = 9'h072;
  localparam logic [8:0] KEY_3     = 9'h07A;
  localparam logic [8:0] KEY_4     = 9'h06B;
  localparam logic [8:0] KEY_5     = 9'h073;
  localparam logic [8:0] KEY_6     = 9'h074;
  localparam logic [8:0] KEY_7     = 9'h06C;
  localparam logic [8:0] KEY_8     = 9'h075;
  localparam logic [8:0] KEY_9     = 9'h07D;

  // Active-low {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_PLUS  = 8'hB9;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_TIMES = 8'h89;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Returns {is_digit, value}
  function automatic logic [4:0] decode_digit(input logic [8:0] code);
    logic [4:0] r;
    case (code)
      KEY_0:   r = {1'b1, 4'd0};
      KEY_1:   r = {1'b1, 4'd1};
      KEY_2:   r = {1'b1, 4'd2};
      KEY_3:   r = {1'b1, 4'd3};
      KEY_4:   r = {1'b1, 4'd4};
      KEY_5:   r = {1'b1, 4'd5};
      KEY_6:   r = {1'b1, 4'd6};
      KEY_7:   r = {1'b1, 4'd7};
      KEY_8:   r = {1'b1, 4'd8};
      KEY_9:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
    logic [7:0] r;
    case (d)
      4'd0:    r = SEG_0;
      4'd1:    r = SEG_1;
      4'd2:    r = SEG_2;
      4'd3:    r = SEG_3;
      4'd4:    r = SEG_4;
      4'd5:    r = SEG_5;
      4'd6:    r = SEG_6;
      4'd7:    r = SEG_7;
      4'd8:    r = SEG_8;
      4'd9:    r = SEG_9;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] to_binary(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_datapath_bin2bcd.sv
`default_nettype none
// =============================================================================
// Module   : bin2bcd
// Purpose  : Sequential double-dabble, 14-bit binary to 4 BCD digits in
//            14 cycles from start; done pulses with the final digits.
// Revision : 1.0 - initial release
// =============================================================================
module bin2bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [29:0] shift_q;
  logic [3:0]  count_q;
  logic        active_q;
  logic        done_q;

  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int d = 0; d < 4; d++) begin
      if (t[14 + 4*d +: 4] >= 4'd5)
        t[14 + 4*d +: 4] = t[14 + 4*d +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  // The load cycle doubles as the first iteration: with an all-zero BCD
  // field no digit needs correcting, so it is a plain shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        shift_q  <= '0;
        count_q  <= '0;
        active_q <= 1'b0;
      end else if (start) begin
        shift_q  <= {15'd0, bin, 1'b0};
        count_q  <= 4'd13;
        active_q <= 1'b1;
      end else if (active_q) begin
        shift_q <= dd_step(shift_q);
        count_q <= count_q - 4'd1;
        if (count_q == 4'd1) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign bcd  = shift_q[29:14];
  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/calc_datapath.sv
`default_nettype none
// =============================================================================
// Module   : calc_datapath
// Purpose  : Two-digit calculator operand capture, 22-cycle arithmetic engine
//            and multiplexed 4-digit 7-segment display.
//            Define CALC_LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Revision : 1.0 - initial release
// =============================================================================
module calc_datapath
  import calc_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] last_change,
  input  logic       key_down,
  input  logic [2:0] state,
  input  logic [1:0] intro,
  output logic [3:0] ssd_ctl,
  output logic [7:0] display,
  output logic       busy
);

  logic [3:0]  a_tens, a_ones, b_tens, b_ones;
  logic [6:0]  snap_a, snap_b;
  logic [1:0]  snap_op;
  logic [2:0]  prev_state;
  calc_phase_e phase, phase_next;
  logic [2:0]  mul_cnt;
  logic [13:0] prod, mcand, prod_step;
  logic [6:0]  mplier;
  logic        calc_neg;
  logic [15:0] res_bcd;
  logic        res_neg;
  logic [SCAN_BITS-1:0] scan_cnt;

  logic [4:0]  key_info;
  logic        digit_valid;
  logic [3:0]  digit_val;
  logic        enter;
  logic        abort;
  logic        bcd_start;
  logic        bcd_done;
  logic [15:0] bcd_out;

  assign key_info    = decode_digit(last_change);
  assign digit_valid = key_info[4];
  assign digit_val   = key_info[3:0];
  assign enter       = key_down && (last_change == KEY_ENTER) &&
                       (state == ST_WAIT_ENTER) && (phase == PH_IDLE);
  assign abort       = (prev_state == ST_SHOW) && (state == ST_A_TENS);
  assign busy        = (phase != PH_IDLE);
  assign prod_step   = mplier[0] ? prod + mcand : prod;
  assign bcd_start   = (phase == PH_MUL) && (mul_cnt == 3'd6);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase <= PH_IDLE;
    else        phase <= phase_next;
  end

  // 1 load + 7 shift-add + 14 conversion cycles regardless of operator
  always_comb begin
    phase_next = phase;
    if (abort) begin
      phase_next = PH_IDLE;
    end else begin
      case (phase)
        PH_IDLE: if (enter) phase_next = PH_LOAD;
        PH_LOAD: phase_next = PH_MUL;
        PH_MUL:  if (mul_cnt == 3'd6) phase_next = PH_BCD;
        PH_BCD:  if (bcd_done) phase_next = PH_IDLE;
        default: phase_next = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_tens     <= '0;
      a_ones     <= '0;
      b_tens     <= '0;
      b_ones     <= '0;
      snap_a     <= '0;
      snap_b     <= '0;
      snap_op    <= '0;
      prev_state <= '0;
      mul_cnt    <= '0;
      prod       <= '0;
      mcand      <= '0;
      mplier     <= '0;
      calc_neg   <= 1'b0;
      res_bcd    <= '0;
      res_neg    <= 1'b0;
      scan_cnt   <= '0;
    end else begin
      prev_state <= state;
      scan_cnt   <= scan_cnt + 1'b1;
      if (abort) begin
        a_tens   <= '0;
        a_ones   <= '0;
        b_tens   <= '0;
        b_ones   <= '0;
        snap_a   <= '0;
        snap_b   <= '0;
        snap_op  <= '0;
        mul_cnt  <= '0;
        prod     <= '0;
        mcand    <= '0;
        mplier   <= '0;
        calc_neg <= 1'b0;
        res_bcd  <= '0;
        res_neg  <= 1'b0;
      end else begin
        if (key_down && digit_valid) begin
          case (state)
            ST_A_TENS: a_tens <= digit_val;
            ST_A_ONES: a_ones <= digit_val;
            ST_B_TENS: b_tens <= digit_val;
            ST_B_ONES: b_ones <= digit_val;
            default: ;
          endcase
        end
        if (enter) begin
          snap_a  <= to_binary(a_tens, a_ones);
          snap_b  <= to_binary(b_tens, b_ones);
          snap_op <= intro;
        end
        case (phase)
          PH_LOAD: begin
            mul_cnt  <= '0;
            mcand    <= 14'(snap_a);
            calc_neg <= 1'b0;
            mplier   <= '0;
            case (snap_op)
              OP_ADD: prod <= 14'(snap_a) + 14'(snap_b);
              OP_SUB: begin
                if (snap_a < snap_b) begin
                  prod     <= 14'(snap_b - snap_a);
                  calc_neg <= 1'b1;
                end else begin
                  prod <= 14'(snap_a - snap_b);
                end
              end
              default: begin
                prod   <= '0;
                mplier <= snap_b;
              end
            endcase
          end
          PH_MUL: begin
            mul_cnt <= mul_cnt + 3'd1;
            prod    <= prod_step;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
          end
          PH_BCD: begin
            if (bcd_done) begin
              res_bcd <= bcd_out;
              res_neg <= calc_neg;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The final shift-add result goes straight into the converter so that
  // conversion overlaps the last multiply step.
  bin2bcd u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .clear (abort),
    .start (bcd_start),
    .bin   (prod_step),
    .bcd   (bcd_out),
    .done  (bcd_done)
  );

  logic [1:0]       sel, pos;
  logic [3:0][3:0]  dig;
  logic             has_glyph;
  logic [7:0]       lead_glyph;
  logic [3:0]       blank;
  logic [7:0]       seg;
`ifdef CALC_LEADING_ZERO_BLANK_EN
  logic             lead_zero;
`endif

  assign sel     = scan_cnt[SCAN_BITS-1 -: 2];
  assign pos     = 2'd3 - sel;
  assign ssd_ctl = ~(4'b1000 >> sel);

  always_comb begin
    dig        = '0;
    has_glyph  = 1'b0;
    lead_glyph = SEG_BLANK;
    blank      = 4'b0000;
    case (state)
      ST_A_TENS, ST_A_ONES: dig[1:0] = {a_tens, a_ones};
      ST_OP: begin
        dig[1:0]  = {a_tens, a_ones};
        has_glyph = 1'b1;
        case (intro)
          OP_ADD:  lead_glyph = SEG_PLUS;
          OP_SUB:  lead_glyph = SEG_MINUS;
          OP_MUL:  lead_glyph = SEG_TIMES;
          default: lead_glyph = SEG_BLANK;
        endcase
      end
      ST_B_TENS, ST_B_ONES, ST_WAIT_ENTER: dig[1:0] = {b_tens, b_ones};
      default: begin
        dig = res_bcd;
        if (res_neg) begin
          has_glyph  = 1'b1;
          lead_glyph = SEG_MINUS;
        end
      end
    endcase
`ifdef CALC_LEADING_ZERO_BLANK_EN
    // Zero run starts at the highest numeric digit; digit 0 is never blanked
    lead_zero = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (!(i == 3 && has_glyph)) begin
        lead_zero = lead_zero && (dig[i] == 4'd0);
        blank[i]  = lead_zero;
      end
    end
`endif
    if (pos == 2'd3 && has_glyph) seg = lead_glyph;
    else if (blank[pos])          seg = SEG_BLANK;
    else                          seg = seg_of_digit(dig[pos]);
  end

  assign display = reset ? seg : SEG_BLANK;

endmodule
`default_nettype wire

// File: tb/tb_calc_datapath.sv
`default_nettype none
// tb_calc_datapath: vector table, randomized runs against a decimal model,
// and hand-written sequences for hold, abort, reset and key filtering.
module tb_calc_datapath;

  localparam int SB = 4;
`ifdef CALC_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [8:0] ENTER = 9'h05A;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] last_change = 9'h000;
  logic       key_down = 1'b0;
  logic [2:0] state = 3'd0;
  logic [1:0] intro = 2'd0;
  logic [3:0] ssd_ctl;
  logic [7:0] display;
  logic       busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cap;

  calc_datapath #(.SCAN_BITS(SB)) dut (
    .clk         (clk),
    .reset       (reset),
    .last_change (last_change),
    .key_down    (key_down),
    .state       (state),
    .intro       (intro),
    .ssd_ctl     (ssd_ctl),
    .display     (display),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int a;
    int b;
    int op;
    int mag;
    bit neg;
  } vec_t;

  function automatic logic [8:0] key_code(input int d);
    case (d)
      0: return 9'h070;
      1: return 9'h069;
      2: return 9'h072;
      3: return 9'h07A;
      4: return 9'h06B;
      5: return 9'h073;
      6: return 9'h074;
      7: return 9'h06C;
      8: return 9'h075;
      default: return 9'h07D;
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  // Expected four glyphs {d3,d2,d1,d0} for what the given state should show
  function automatic logic [31:0] exp_disp(input int st, input int a, input int b,
                                           input int op, input int mag, input bit neg);
    int          val;
    int          v;
    int          d[4];
    bit          has_g;
    bit          zero_run;
    logic [7:0]  g;
    logic [31:0] r;
    has_g = 1'b0;
    g     = 8'hFF;
    r     = 32'hFFFF_FFFF;
    case (st)
      0, 1: val = a;
      2: begin
        val   = a;
        has_g = 1'b1;
        g     = (op == 0) ? 8'hB9 : (op == 1) ? 8'hBF : 8'h89;
      end
      3, 4, 5: val = b;
      default: begin
        val = mag;
        if (neg) begin
          has_g = 1'b1;
          g     = 8'hBF;
        end
      end
    endcase
    v = val;
    for (int i = 0; i < 4; i++) begin
      d[i] = v % 10;
      v    = v / 10;
    end
    zero_run = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (i == 3 && has_g) begin
        r[31:24] = g;
      end else begin
        zero_run = zero_run && (d[i] == 0);
        r[i*8 +: 8] = (BLANK && zero_run && i != 0) ? 8'hFF : seg_of(d[i]);
      end
    end
    return r;
  endfunction

  task automatic model(input int a, input int b, input int op, output int mag, output bit neg);
    neg = 1'b0;
    if (op == 0) mag = a + b;
    else if (op == 1) begin
      mag = (a >= b) ? a - b : b - a;
      neg = (a < b);
    end else mag = a * b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_state(input int s);
    @(negedge clk);
    state    = 3'(s);
    key_down = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [8:0] code);
    @(negedge clk);
    last_change = code;
    key_down    = 1'b1;
    @(negedge clk);
    key_down    = 1'b0;
  endtask

  task automatic sample_digit();
    case (ssd_ctl)
      4'b0111: cap[31:24] = display;
      4'b1011: cap[23:16] = display;
      4'b1101: cap[15:8]  = display;
      4'b1110: cap[7:0]   = display;
      default: ;
    endcase
  endtask

  task automatic read_disp(input string name, input logic [31:0] exp);
    int         bad;
    logic [3:0] prev;
    bad  = 0;
    cap  = 32'h0;
    prev = ssd_ctl;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      sample_digit();
      if (!(ssd_ctl inside {4'b0111, 4'b1011, 4'b1101, 4'b1110})) bad++;
      else if (ssd_ctl != prev && ssd_ctl != {prev[0], prev[3:1]}) bad++;
      prev = ssd_ctl;
    end
    check({name, "_scan"}, bad, 0);
    check(name, cap, exp);
  endtask

  task automatic run_calc(input int a, input int b, input int op, input int mag,
                          input bit neg, input string tag);
    int n;
    set_state(0);
    press(key_code(a / 10));
    set_state(1);
    press(key_code(a % 10));
    intro = 2'(op);
    set_state(2);
    read_disp({tag, "_op"}, exp_disp(2, a, b, op, 0, 1'b0));
    set_state(3);
    press(key_code(b / 10));
    set_state(4);
    press(key_code(b % 10));
    set_state(5);
    read_disp({tag, "_b"}, exp_disp(5, a, b, op, 0, 1'b0));
    press(ENTER);
    check({tag, "_busy_rise"}, busy, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, n, 22);
    set_state(6);
    read_disp({tag, "_res"}, exp_disp(6, a, b, op, mag, neg));
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    int ra, rb, rop, rmag;
    bit rneg;

    vecs[0] = '{12, 34, 0, 46,   1'b0};
    vecs[1] = '{5,  37, 1, 32,   1'b1};
    vecs[2] = '{99, 99, 2, 9801, 1'b0};
    vecs[3] = '{0,  0,  0, 0,    1'b0};
    vecs[4] = '{99, 99, 0, 198,  1'b0};
    vecs[5] = '{37, 5,  1, 32,   1'b0};
    vecs[6] = '{7,  7,  1, 0,    1'b0};
    vecs[7] = '{10, 9,  2, 90,   1'b0};
    vecs[8] = '{0,  99, 2, 0,    1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ssd", ssd_ctl, 4'b0111);
    check("rst_display", display, 8'hFF);
    reset = 1'b1;

    for (int i = 0; i < 9; i++)
      run_calc(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].mag, vecs[i].neg,
               $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      ra  = $urandom_range(0, 99);
      rb  = $urandom_range(0, 99);
      rop = $urandom_range(0, 2);
      model(ra, rb, rop, rmag, rneg);
      run_calc(ra, rb, rop, rmag, rneg, $sformatf("rnd%0d", i));
    end

    // Old result held while busy; a second enter while busy is ignored
    run_calc(12, 34, 0, 46, 1'b0, "hold_setup");
    set_state(4);
    press(key_code(9));
    set_state(5);
    press(ENTER);
    n   = 0;
    cap = 32'h0;
    while (busy && n < 100) begin
      n++;
      key_down = 1'b0;
      if (n == 3) begin
        last_change = ENTER;
        key_down    = 1'b1;
      end
      if (n == 5) state = 3'd6;
      if (n >= 6 && n <= 21) sample_digit();
      @(negedge clk);
    end
    key_down = 1'b0;
    check("hold_busy_len", n, 22);
    check("hold_old_result", cap, exp_disp(6, 12, 34, 0, 46, 1'b0));
    read_disp("hold_new_result", exp_disp(6, 12, 39, 0, 51, 1'b0));

    // 110 -> 000 aborts an in-flight computation and clears everything
    set_state(5);
    press(ENTER);
    n = 0;
    while (busy && n < 4) begin
      n++;
      @(negedge clk);
    end
    state = 3'd6;
    @(negedge clk);
    state = 3'd0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    n = 0;
    repeat (30) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("abort_busy_stays_low", n, 0);
    read_disp("abort_a_clear", exp_disp(0, 0, 0, 0, 0, 1'b0));
    set_state(6);
    read_disp("abort_result_clear", exp_disp(6, 0, 0, 0, 0, 1'b0));

    // Reset at busy cycle 10
    run_calc(21, 3, 2, 63, 1'b0, "rst_setup");
    set_state(5);
    press(ENTER);
    repeat (9) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ssd", ssd_ctl, 4'b0111);
    check("midrst_display", display, 8'hFF);
    @(negedge clk);
    check("midrst_display_hold", display, 8'hFF);
    reset = 1'b1;
    n = 0;
    repeat (30) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("midrst_busy_stays_low", n, 0);
    set_state(6);
    read_disp("midrst_result", exp_disp(6, 0, 0, 0, 0, 1'b0));

    // Non-digit codes and digits in non-capture states leave operands alone
    set_state(0);
    press(key_code(5));
    read_disp("nd_a5", exp_disp(0, 50, 0, 0, 0, 1'b0));
    press(9'h01C);
    press(9'h170);
    read_disp("nd_1c", exp_disp(0, 50, 0, 0, 0, 1'b0));
    set_state(2);
    press(key_code(7));
    set_state(5);
    press(key_code(7));
    set_state(1);
    press(9'h01C);
    read_disp("nd_ignored", exp_disp(1, 50, 0, 0, 0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
